// File: rtl/tcb_peri_uart_pkg.sv
// Shared types for the UART receive-side controller.
package tcb_peri_uart_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ABR_FALL = 2'd1,
    ABR_LOW  = 2'd2,
    ABR_SKIP = 2'd3
  } uart_rx_ctl_st_t;

endpackage

// File: rtl/tcb_peri_uart_rx_ctl_if.sv
// Ready/valid byte stream leaving the RX controller FIFO.
interface tcb_peri_uart_rx_ctl_if #(
  parameter int DW = 8
) ();
  logic          str_vld;
  logic          str_rdy;
  logic [DW-1:0] str_dat;

  modport master (output str_vld, output str_dat, input str_rdy);
  modport slave  (input str_vld, input str_dat, output str_rdy);
endinterface

// File: rtl/tcb_peri_uart_fifo.sv
// Synchronous register FIFO, show-ahead read; a push while full is accepted only with a same-cycle pop.
module tcb_peri_uart_fifo #(
  parameter int DW = 8,
  parameter int FA = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [FA:0]   cnt_o
);
  localparam int DEPTH = 2 ** FA;

  logic [DW-1:0] mem_q [DEPTH];
  logic [FA-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [FA:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign full_o  = (cnt_q == (FA+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) wr_d = wr_q + FA'(1);
    if (rd_en) rd_d = rd_q + FA'(1);
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + (FA+1)'(1);
      2'b01:   cnt_d = cnt_q - (FA+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/tcb_peri_uart_rx_ctl.sv
// UART RX controller: des baud config (software or 0x55 autobaud), rxd gating, output FIFO.
// state    | meaning
// RUN      | normal reception, rxd passed to des, software cfg writes accepted
// ABR_FALL | autobaud armed, waiting for the start-bit falling edge
// ABR_LOW  | measuring the start-bit low time
// ABR_SKIP | discarding the rest of the sync char until 2 bit times of idle
module tcb_peri_uart_rx_ctl
  import tcb_peri_uart_pkg::*;
#(
  parameter int            RW      = 16,
  parameter int            DW      = 8,
  parameter int            FA      = 2,
  parameter logic [RW-1:0] BDR_RST = 16'd867,
  parameter int            ABR_MIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rxd,
  output logic                   des_rxd,
  output logic [RW-1:0]          cfg_bdr,
  output logic [RW-1:0]          cfg_smp,
  input  logic                   des_vld,
  input  logic [DW-1:0]          des_dat,
  input  logic                   sw_bdr_wen,
  input  logic [RW-1:0]          sw_bdr_dat,
  input  logic                   abr_req,
  output logic                   sts_bsy,
  output logic                   sts_err,
  output logic                   sts_ovf,
  input  logic                   sts_clr,
  output logic [FA:0]            sts_cnt,
  tcb_peri_uart_rx_ctl_if.master str
);
  // One spare bit beyond the measure range so the skip target 2*(bdr+1) always fits.
  localparam int            CW      = RW + 2;
  localparam logic [CW-1:0] CNT_TMO = CW'(2 ** RW);
  localparam logic [CW-1:0] CNT_MIN = CW'(ABR_MIN);

  uart_rx_ctl_st_t st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   bdr_q, bdr_d, smp_q, smp_d;
  logic            err_q, err_d, ovf_q, ovf_d;
  logic            rxd_q;
  logic            abr_err;
  logic [RW-1:0]   meas_m1;
  logic [CW-1:0]   skip_tgt;
  logic            fifo_pop, fifo_full, fifo_empty, fifo_ovf;

  assign meas_m1  = RW'(cnt_q - CW'(1));
  assign skip_tgt = ({{(CW-RW){1'b0}}, bdr_q} + CW'(1)) << 1;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    bdr_d   = bdr_q;
    smp_d   = smp_q;
    abr_err = 1'b0;
    case (st_q)
      RUN: begin
        if (sw_bdr_wen) begin
          bdr_d = sw_bdr_dat;
          smp_d = sw_bdr_dat >> 1;
        end
        if (abr_req) st_d = ABR_FALL;
      end
      ABR_FALL: begin
        // The edge cycle already has rxd low, so it is the first counted cycle.
        if (rxd_q && !rxd) begin
          cnt_d = CW'(1);
          st_d  = ABR_LOW;
        end
      end
      ABR_LOW: begin
        if (rxd) begin
          if (cnt_q >= CNT_MIN) begin
            bdr_d = meas_m1;
            smp_d = meas_m1 >> 1;
          end else begin
            abr_err = 1'b1;
          end
          cnt_d = '0;
          st_d  = ABR_SKIP;
        end else if (cnt_q == CNT_TMO) begin
          abr_err = 1'b1;
          st_d    = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ABR_SKIP: begin
        if (!rxd) cnt_d = '0;
        else if (cnt_q + CW'(1) == skip_tgt) st_d = RUN;
        else cnt_d = cnt_q + CW'(1);
      end
      default: st_d = RUN;
    endcase
  end

  assign fifo_pop = str.str_rdy & ~fifo_empty;
  assign fifo_ovf = des_vld & fifo_full & ~fifo_pop;

  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (sts_clr) begin
      err_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (abr_err)  err_d = 1'b1;
    if (fifo_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= RUN;
      cnt_q <= '0;
      bdr_q <= BDR_RST;
      smp_q <= BDR_RST >> 1;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      rxd_q <= 1'b1;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bdr_q <= bdr_d;
      smp_q <= smp_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      rxd_q <= rxd;
    end
  end

  assign des_rxd = (st_q == RUN) ? rxd : 1'b1;
  assign sts_bsy = (st_q != RUN);
  assign sts_err = err_q;
  assign sts_ovf = ovf_q;
  assign cfg_bdr = bdr_q;
  assign cfg_smp = smp_q;
  assign str.str_vld = ~fifo_empty;

  tcb_peri_uart_fifo #(.DW(DW), .FA(FA)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (des_vld),
    .pop_i   (fifo_pop),
    .din_i   (des_dat),
    .dout_o  (str.str_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (sts_cnt)
  );
endmodule
